// File: rtl/input_conditioner.sv
// Cabinet input conditioner: sync + debounce for buttons/coin/test, and coin credit pulse generator.
// Optional credit meter (coin_total, meter_clr) is built when INPUT_COND_COIN_METER_EN is defined.
module input_conditioner #(
    parameter int NUM_BTN          = 8,
    parameter int DEBOUNCE_TICKS   = 6,
    parameter int COIN_PULSE_TICKS = 40,
    parameter int COIN_GAP_TICKS   = 40,
    parameter int COIN_Q_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               coin_raw,
    input  logic               test_raw,
`ifdef INPUT_COND_COIN_METER_EN
    input  logic               meter_clr,
    output logic [15:0]        coin_total,
`endif
    output logic [NUM_BTN-1:0] buttons,
    output logic               coin_n,
    output logic               self_test,
    output logic [3:0]         coin_pending,
    output logic               coin_overflow
);

    localparam int NIN      = NUM_BTN + 2;
    localparam int COIN_BIT = NUM_BTN;
    localparam int TEST_BIT = NUM_BTN + 1;

    localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_TICKS - 1);
    localparam logic [3:0] Q_MAX      = 4'(COIN_Q_DEPTH);
    localparam logic [7:0] PULSE_LAST = 8'(COIN_PULSE_TICKS - 1);
    localparam logic [7:0] GAP_LAST   = 8'(COIN_GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

    logic [NIN-1:0] raw_all;
    logic [NIN-1:0] sync_p0, sync_p1;
    logic [NIN-1:0] stable_p2;
    logic [3:0]     db_cnt [NIN];
    coin_state_t    coin_state;
    logic [7:0]     coin_timer;
    logic           coin_enq, coin_deq;

    assign raw_all = {test_raw, coin_raw, btn_raw};

    // Stage p0/p1: two-flop synchroniser, every clk
    // Stage p2: per-bit debounce, only on tick_en
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            stable_p2 <= '0;
            for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw_all;
            sync_p1 <= sync_p0;
            if (tick_en) begin
                for (int i = 0; i < NIN; i++) begin
                    if (sync_p1[i] == stable_p2[i]) begin
                        db_cnt[i] <= '0;
                    end else if (db_cnt[i] == DB_LAST) begin
                        stable_p2[i] <= sync_p1[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    assign buttons   = stable_p2[NUM_BTN-1:0];
    assign self_test = stable_p2[TEST_BIT];

    // Enqueue fires on the same edge that the debounced coin level goes 0->1
    assign coin_enq = tick_en && sync_p1[COIN_BIT] && !stable_p2[COIN_BIT]
                      && (db_cnt[COIN_BIT] == DB_LAST);
    assign coin_deq = tick_en && (coin_state == IDLE) && (coin_pending != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_pending  <= 4'd0;
            coin_overflow <= 1'b0;
        end else begin
            case ({coin_enq, coin_deq})
                2'b10: begin
                    if (coin_pending == Q_MAX) coin_overflow <= 1'b1;
                    else                       coin_pending  <= coin_pending + 4'd1;
                end
                2'b01:   coin_pending <= coin_pending - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_state <= IDLE;
            coin_timer <= 8'd0;
            coin_n     <= 1'b1;
        end else if (tick_en) begin
            case (coin_state)
                IDLE: begin
                    if (coin_pending != 4'd0) begin
                        coin_state <= PULSE;
                        coin_timer <= PULSE_LAST;
                        coin_n     <= 1'b0;
                    end
                end
                PULSE: begin
                    if (coin_timer == 8'd0) begin
                        coin_state <= GAP;
                        coin_timer <= GAP_LAST;
                        coin_n     <= 1'b1;
                    end else begin
                        coin_timer <= coin_timer - 8'd1;
                    end
                end
                GAP: begin
                    if (coin_timer == 8'd0) coin_state <= IDLE;
                    else                    coin_timer <= coin_timer - 8'd1;
                end
                default: begin
                    coin_state <= IDLE;
                    coin_n     <= 1'b1;
                end
            endcase
        end
    end

`ifdef INPUT_COND_COIN_METER_EN
    // A clear coinciding with a dequeue wins
    always_ff @(posedge clk) begin
        if (rst || meter_clr) coin_total <= 16'd0;
        else if (coin_deq)    coin_total <= coin_total + 16'd1;
    end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: debounce vector table plus coin pulse scoreboard.
// Meter checks are included when INPUT_COND_COIN_METER_EN is defined.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b0;
    logic [7:0] btn_raw = 8'h00;
    logic       coin_raw = 1'b0;
    logic       test_raw = 1'b0;
    logic [7:0] buttons;
    logic       coin_n;
    logic       self_test;
    logic [3:0] coin_pending;
    logic       coin_overflow;
`ifdef INPUT_COND_COIN_METER_EN
    logic        meter_clr = 1'b0;
    logic [15:0] coin_total;
`endif

    input_conditioner dut (
        .clk           (clk),
        .rst           (rst),
        .tick_en       (tick_en),
        .btn_raw       (btn_raw),
        .coin_raw      (coin_raw),
        .test_raw      (test_raw),
`ifdef INPUT_COND_COIN_METER_EN
        .meter_clr     (meter_clr),
        .coin_total    (coin_total),
`endif
        .buttons       (buttons),
        .coin_n        (coin_n),
        .self_test     (self_test),
        .coin_pending  (coin_pending),
        .coin_overflow (coin_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int sb[$];
    logic [8:0] bq[$];

    typedef struct {
        logic [7:0] btn;
        logic       tst;
        int         hold;
        logic [7:0] exp_btn;
        logic       exp_tst;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick_en) k++;
        end
        #1;
    endtask

    // One tick_en pulse every 4 clk
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            tick_en = (cnt == 3);
            cnt = (cnt + 1) % 4;
        end
    end

    // Coin monitor: measures low/high widths in ticks and scores each finished pulse
    initial begin
        int  low_run = 0;
        int  high_run = 0;
        bit  have_prev = 0;
        logic t;
        forever begin
            @(posedge clk);
            t = tick_en;
            @(negedge clk);
            if (rst) begin
                low_run = 0; high_run = 0; have_prev = 0;
            end else if (t) begin
                if (!coin_n) begin
                    if (low_run == 0 && have_prev) begin
                        checks++;
                        if (high_run < 41) begin
                            errors++;
                            $display("FAIL coin_gap: high %0d ticks, expected at least 41", high_run);
                        end
                    end
                    low_run++;
                end else begin
                    if (low_run > 0) begin
                        pulses++;
                        if (sb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_pulse: low %0d ticks, no credit expected", low_run);
                        end else begin
                            chk("coin_low_ticks", low_run, sb.pop_front());
                        end
                        have_prev = 1; high_run = 0; low_run = 0;
                    end
                    high_run++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic coin_closure(input int hi, input int lo);
        coin_raw = 1'b1;
        wait_ticks(hi);
        coin_raw = 1'b0;
        wait_ticks(lo);
    endtask

    initial begin
        int p0;
        vecs[0]  = '{8'h05, 1'b0, 5, 8'h00, 1'b0};
        vecs[1]  = '{8'h05, 1'b0, 1, 8'h05, 1'b0};
        vecs[2]  = '{8'h05, 1'b0, 4, 8'h05, 1'b0};
        vecs[3]  = '{8'h0D, 1'b0, 4, 8'h05, 1'b0};
        vecs[4]  = '{8'h05, 1'b0, 6, 8'h05, 1'b0};
        vecs[5]  = '{8'h05, 1'b1, 6, 8'h05, 1'b1};
        vecs[6]  = '{8'h00, 1'b1, 5, 8'h05, 1'b1};
        vecs[7]  = '{8'h00, 1'b0, 6, 8'h00, 1'b0};
        vecs[8]  = '{8'hFF, 1'b0, 6, 8'hFF, 1'b0};
        vecs[9]  = '{8'hA5, 1'b1, 3, 8'hFF, 1'b0};
        vecs[10] = '{8'hA5, 1'b1, 3, 8'hA5, 1'b1};
        vecs[11] = '{8'h00, 1'b0, 6, 8'h00, 1'b0};

        repeat (5) @(posedge clk);
        #1;
        chk("rst_buttons", buttons, 8'h00);
        chk("rst_self_test", self_test, 1'b0);
        chk("rst_coin_n", coin_n, 1'b1);
        chk("rst_coin_pending", coin_pending, 4'd0);
        chk("rst_coin_overflow", coin_overflow, 1'b0);
        rst = 1'b0;
        wait_ticks(1);

        // Debounce table
        for (int i = 0; i < 12; i++) begin
            btn_raw  = vecs[i].btn;
            test_raw = vecs[i].tst;
            bq.push_back({vecs[i].exp_tst, vecs[i].exp_btn});
            wait_ticks(vecs[i].hold);
            chk($sformatf("debounce_row%0d", i), {self_test, buttons}, bq.pop_front());
            chk($sformatf("coin_idle_row%0d", i), coin_n, 1'b1);
        end

        // Single credit
        coin_raw = 1'b1;
        sb.push_back(40);
        wait_ticks(6);
        chk("single_pending_1", coin_pending, 4'd1);
        wait_ticks(1);
        chk("single_pending_0", coin_pending, 4'd0);
        chk("single_coin_low", coin_n, 1'b0);
        wait_ticks(13);
        coin_raw = 1'b0;
        wait_ticks(100);
        chk("single_pulse_count", pulses, 1);
        chk("single_sb_empty", sb.size(), 0);

        // Six closures during one pulse: one issued, four queued, one dropped
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(40);
            coin_raw = 1'b1;
            wait_ticks(7);
            if (i == 4) begin
                chk("burst_pending_full", coin_pending, 4'd4);
                chk("burst_no_ovf_yet", coin_overflow, 1'b0);
            end
            if (i == 5) begin
                chk("burst_pending_peak", coin_pending, 4'd4);
                chk("burst_overflow", coin_overflow, 1'b1);
            end
            coin_raw = 1'b0;
            wait_ticks(7);
        end
        wait_ticks(400);
        chk("burst_pulse_count", pulses - p0, 5);
        chk("burst_sb_empty", sb.size(), 0);
        chk("burst_pending_drained", coin_pending, 4'd0);
        chk("burst_overflow_sticky", coin_overflow, 1'b1);

        // Reset mid-pulse with two credits queued
        p0 = pulses;
        btn_raw = 8'h05;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(40);
            coin_closure(6, 6);
        end
        chk("midrst_pending_2", coin_pending, 4'd2);
        chk("midrst_coin_low", coin_n, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midrst_coin_n", coin_n, 1'b1);
        chk("midrst_pending", coin_pending, 4'd0);
        chk("midrst_overflow", coin_overflow, 1'b0);
        chk("midrst_buttons", buttons, 8'h00);
        rst = 1'b0;
        btn_raw = 8'h00;
        wait_ticks(150);
        chk("midrst_no_pulses", pulses - p0, 0);
        chk("midrst_coin_idle", coin_n, 1'b1);

`ifdef INPUT_COND_COIN_METER_EN
        chk("meter_reset", coin_total, 16'd0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(40);
            coin_closure(7, 7);
        end
        wait_ticks(250);
        chk("meter_three", coin_total, 16'd3);
        sb.push_back(40);
        coin_raw = 1'b1;
        wait_ticks(6);
        meter_clr = 1'b1;
        wait_ticks(1);
        meter_clr = 1'b0;
        chk("meter_clr_wins", coin_total, 16'd0);
        chk("meter_fourth_low", coin_n, 1'b0);
        coin_raw = 1'b0;
        wait_ticks(100);
        chk("meter_sb_empty", sb.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
